// File: rtl/conv_layer_seq.sv
// Layer sequencer for conv2d_3x3: queues layer descriptors and
// drives the kernel config/start for one layer at a time.
module conv_layer_seq #(
  parameter int CHN_WIDTH = 8,
  parameter int FMS_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int TO_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 abort,
  input  logic                 desc_valid,
  output logic                 desc_ready,
  input  logic [CHN_WIDTH-1:0] desc_ci,
  input  logic [CHN_WIDTH-1:0] desc_co,
  input  logic                 desc_stride,
  input  logic [FMS_WIDTH-1:0] desc_ifm_size,
  input  logic                 desc_last,
  output logic [CHN_WIDTH-1:0] cfg_ci,
  output logic [CHN_WIDTH-1:0] cfg_co,
  output logic                 cfg_stride,
  output logic [FMS_WIDTH-1:0] cfg_ifm_size,
  output logic                 start_conv,
  input  logic                 conv_done,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 seq_done,
  output logic [15:0]          layer_cnt,
  output logic                 err_cfg,
  output logic                 err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2*CHN_WIDTH + FMS_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE, START, RUN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [AW:0]   wptr, rptr;
  logic          full, empty;
  logic          desc_ok, push, store;
  logic          pop, to_hit;
  logic [TO_WIDTH-1:0] wd, wd_inc;
  logic          last_r;

  // Extra pointer bit tells full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign desc_ready = !full && !err_timeout;
  assign desc_ok = (desc_ci != '0) && (desc_co != '0) &&
                   (desc_ifm_size >= FMS_WIDTH'(3));
  assign push  = desc_valid && desc_ready && !abort;
  assign store = push && desc_ok;

  assign head   = mem[rptr[AW-1:0]];
  assign wd_inc = wd + TO_WIDTH'(1);

  assign busy       = (state != IDLE);
  assign start_conv = (state == START);
  assign layer_done = (state == DONE);
  assign seq_done   = (state == DONE) && last_r;

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    to_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = START;
          pop       = 1'b1;
        end
      end
      START: state_nxt = RUN;
      RUN: begin
        if (conv_done) begin
          state_nxt = DONE;
        end else if (&wd_inc) begin
          state_nxt = IDLE;
          to_hit    = 1'b1;
        end
      end
      DONE: begin
        if (!empty) begin
          state_nxt = START;
          pop       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      pop       = 1'b0;
      to_hit    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Descriptor storage; only legal descriptors are written.
  always_ff @(posedge clk) begin
    if (store)
      mem[wptr[AW-1:0]] <= {desc_ci, desc_co, desc_stride,
                            desc_ifm_size, desc_last};
  end

  // FIFO pointers; abort and timeout flush the queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (abort || to_hit) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (store) wptr <= wptr + (AW+1)'(1);
      if (pop)   rptr <= rptr + (AW+1)'(1);
    end
  end

  // Kernel config, loaded only when a layer is popped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_ci       <= '0;
      cfg_co       <= '0;
      cfg_stride   <= 1'b0;
      cfg_ifm_size <= '0;
      last_r       <= 1'b0;
    end else if (pop) begin
      {cfg_ci, cfg_co, cfg_stride,
       cfg_ifm_size, last_r} <= head;
    end
  end

  // Watchdog: cleared in START, counts RUN cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd <= '0;
    end else if (abort || to_hit || state == START) begin
      wd <= '0;
    end else if (state == RUN && !conv_done) begin
      wd <= wd_inc;
    end
  end

  // Sticky error flags, cleared only by abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
    end else if (abort) begin
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (push && !desc_ok) err_cfg     <= 1'b1;
      if (to_hit)           err_timeout <= 1'b1;
    end
  end

  // Completed-layer counter, wraps naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      layer_cnt <= '0;
    else if (state == DONE && !abort)
      layer_cnt <= layer_cnt + 16'd1;
  end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Scoreboard bench for conv_layer_seq: directed descriptors,
// expected kernel starts/completions checked by a monitor.
module tb_conv_layer_seq;

  localparam int CW = 8;
  localparam int FW = 8;
  localparam int DP = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rstn, abort;
  logic          desc_valid, desc_ready;
  logic [CW-1:0] desc_ci, desc_co;
  logic          desc_stride, desc_last;
  logic [FW-1:0] desc_ifm_size;
  logic [CW-1:0] cfg_ci, cfg_co;
  logic          cfg_stride;
  logic [FW-1:0] cfg_ifm_size;
  logic          start_conv, conv_done, busy;
  logic          layer_done, seq_done;
  logic [15:0]   layer_cnt;
  logic          err_cfg, err_timeout;

  conv_layer_seq #(
    .CHN_WIDTH(CW), .FMS_WIDTH(FW),
    .DEPTH(DP), .TO_WIDTH(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .abort(abort),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ci(desc_ci), .desc_co(desc_co),
    .desc_stride(desc_stride),
    .desc_ifm_size(desc_ifm_size),
    .desc_last(desc_last),
    .cfg_ci(cfg_ci), .cfg_co(cfg_co),
    .cfg_stride(cfg_stride),
    .cfg_ifm_size(cfg_ifm_size),
    .start_conv(start_conv), .conv_done(conv_done),
    .busy(busy), .layer_done(layer_done),
    .seq_done(seq_done), .layer_cnt(layer_cnt),
    .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ci;
    logic [CW-1:0] co;
    logic          st;
    logic [FW-1:0] sz;
  } cfg_t;

  typedef struct packed {
    logic        sq;
    logic [15:0] cnt;
  } dn_t;

  cfg_t        exp_start[$];
  dn_t         exp_done[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt;
  logic        cnt_pend = 1'b0;
  logic [15:0] cnt_want;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int ci, int co, int st, int sz,
                      int lst, bit expect_run);
    chk("desc_ready_at_push", desc_ready, 1);
    desc_ci       = CW'(ci);
    desc_co       = CW'(co);
    desc_stride   = st[0];
    desc_ifm_size = FW'(sz);
    desc_last     = lst[0];
    desc_valid    = 1'b1;
    if (expect_run)
      exp_start.push_back({CW'(ci), CW'(co), st[0], FW'(sz)});
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic finish_layer(logic lst, logic nxt);
    exp_cnt = exp_cnt + 16'd1;
    exp_done.push_back({lst, exp_cnt});
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("layer_done_n1", layer_done, 1);
    tick();
    chk("start_n2", start_conv, nxt);
  endtask

  // Monitor: checks every start/completion the DUT presents.
  always @(negedge clk) begin
    if (cnt_pend) begin
      chk("layer_cnt", layer_cnt, cnt_want);
      cnt_pend <= 1'b0;
    end
    if (rstn && start_conv) begin
      if (exp_start.size() == 0) begin
        chk("unexpected_start", start_conv, 0);
      end else begin
        cfg_t c;
        c = exp_start.pop_front();
        chk("cfg_at_start",
            {cfg_ci, cfg_co, cfg_stride, cfg_ifm_size}, c);
      end
    end
    if (rstn && layer_done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_layer_done", layer_done, 0);
      end else begin
        dn_t d;
        d = exp_done.pop_front();
        chk("seq_done", seq_done, d.sq);
        cnt_pend <= 1'b1;
        cnt_want <= d.cnt;
      end
    end
  end

  initial begin
    rstn = 1'b0; abort = 1'b0; conv_done = 1'b0;
    desc_valid = 1'b0; desc_ci = '0; desc_co = '0;
    desc_stride = 1'b0; desc_ifm_size = '0;
    desc_last = 1'b0;
    exp_cnt = '0;
    tick(); tick();
    chk("rst_ready", desc_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_conv, 0);
    chk("rst_cnt", layer_cnt, 0);
    chk("rst_errs", {err_cfg, err_timeout}, 0);
    chk("rst_cfg", {cfg_ci, cfg_co, cfg_stride, cfg_ifm_size}, 0);
    rstn = 1'b1;
    tick();

    // single layer
    push(64, 64, 0, 16, 1, 1);
    tick();
    chk("t1_start", start_conv, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_once", start_conv, 0);
    repeat (98) tick();
    chk("t1_cfg_stable",
        {cfg_ci, cfg_co, cfg_stride, cfg_ifm_size},
        {8'd64, 8'd64, 1'b0, 8'd16});
    finish_layer(1'b1, 1'b0);
    chk("t1_busy_fall", busy, 0);
    chk("t1_cnt", layer_cnt, 1);

    // back-to-back, FIFO fills while kernel stalled
    push(1, 2, 0, 8, 0, 1);
    tick();
    chk("t2_start_a", start_conv, 1);
    push(2, 3, 1, 9, 0, 1);
    push(3, 4, 0, 10, 0, 1);
    push(4, 5, 1, 11, 0, 1);
    push(5, 6, 0, 12, 1, 1);
    chk("t2_full_ready", desc_ready, 0);
    desc_ci = 8'd9; desc_co = 8'd9; desc_ifm_size = 8'd9;
    desc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_held_off", desc_ready, 0);
    end
    desc_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    exp_done.push_back({1'b0, exp_cnt});
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t2_done_a", layer_done, 1);
    chk("t2_ready_pop_cycle", desc_ready, 0);
    tick();
    chk("t2_start_b", start_conv, 1);
    chk("t2_ready_after_pop", desc_ready, 1);
    repeat (3) tick();
    finish_layer(1'b0, 1'b1);
    repeat (3) tick();
    finish_layer(1'b0, 1'b1);
    repeat (3) tick();
    finish_layer(1'b0, 1'b1);
    repeat (3) tick();
    finish_layer(1'b1, 1'b0);
    chk("t2_cnt", layer_cnt, 6);

    // illegal descriptors dropped
    push(0, 5, 0, 8, 0, 0);
    chk("t3_err_cfg", err_cfg, 1);
    push(5, 0, 0, 8, 0, 0);
    push(5, 5, 0, 2, 1, 0);
    chk("t3_idle", busy, 0);
    push(7, 3, 1, 5, 1, 1);
    tick();
    chk("t3_start", start_conv, 1);
    repeat (2) tick();
    finish_layer(1'b1, 1'b0);
    chk("t3_err_sticky", err_cfg, 1);

    // watchdog expiry
    push(10, 10, 0, 20, 0, 1);
    tick();
    chk("t4_start", start_conv, 1);
    push(11, 11, 0, 20, 0, 0);
    push(12, 12, 0, 20, 1, 0);
    repeat ((1 << TW) - 3) tick();
    chk("t4_not_yet", err_timeout, 0);
    chk("t4_busy_run", busy, 1);
    tick();
    chk("t4_timeout", err_timeout, 1);
    chk("t4_busy_off", busy, 0);
    chk("t4_ready_off", desc_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_flushed", start_conv, 0);
    end
    chk("t4_cnt_hold", layer_cnt, exp_cnt);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_to", err_timeout, 0);
    chk("t4_abort_cfg", err_cfg, 0);
    chk("t4_abort_ready", desc_ready, 1);

    // abort in RUN with queued entries and a push
    push(20, 21, 1, 30, 0, 1);
    tick();
    chk("t5_start", start_conv, 1);
    push(21, 22, 0, 30, 0, 0);
    push(22, 23, 0, 30, 1, 0);
    tick();
    abort = 1'b1;
    desc_ci = 8'd33; desc_co = 8'd33; desc_ifm_size = 8'd33;
    desc_valid = 1'b1;
    tick();
    abort = 1'b0;
    desc_valid = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_cfg_hold", cfg_ci, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_start", start_conv, 0);
    end
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t5_stray_done", layer_done, 0);
    tick();
    chk("t5_cnt_hold", layer_cnt, exp_cnt);

    // async reset mid-RUN
    push(30, 31, 0, 40, 1, 1);
    tick();
    chk("t6_start", start_conv, 1);
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", desc_ready, 1);
    chk("t6_rst_cnt", layer_cnt, 0);
    chk("t6_rst_cfg", {cfg_ci, cfg_co, cfg_stride, cfg_ifm_size}, 0);
    exp_cnt = '0;
    tick();
    rstn = 1'b1;
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("t6_done_ignored", layer_done, 0);
    push(40, 41, 1, 50, 1, 1);
    tick();
    chk("t6_start_new", start_conv, 1);
    repeat (2) tick();
    finish_layer(1'b1, 1'b0);
    tick();
    chk("t6_cnt", layer_cnt, 1);
    chk("sb_start_drained", exp_start.size(), 0);
    chk("sb_done_drained", exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
